// File: rtl/rsa_exp_scheduler.sv
// rsa_exp_scheduler
// Sequences one modular exponentiation result = y^d mod N, right-to-left
// binary (LSB first). The modulo-product unit first supplies
// t = y*2^WIDTH mod N. After that, a single Montgomery multiplier is shared
// between two kinds of step:
//   - multiply: m = mont(m, t)
//   - square:   t = mont(t, t)
// m starts at plain 1 and t lives in the Montgomery domain. Each multiply
// therefore leaves m in the plain domain, so m is the final result with no
// conversion step.
//
// Optional feature: define EARLY_TERM_EN to stop as soon as no set bits of d
// remain. Without it, all WIDTH bit positions are walked, so latency does not
// depend on the value of d.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   start, N, y, d             request and operands (sampled in IDLE only)
//   mp_start, mp_y             precompute request, latched base
//   mp_done, mp_result         precompute completion and y*2^WIDTH mod N
//   mont_start, mont_a, mont_b Montgomery request and held operands
//   mont_done, mont_result     Montgomery completion and a*b*2^-WIDTH mod N
//   busy                       high in every state except IDLE
//   result, finish             y^d mod N and its one-cycle valid pulse
module rsa_exp_scheduler #(
    parameter int WIDTH = 256,
    parameter int CNT_W = 9     // 2^CNT_W must exceed WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] d,
    output logic             mp_start,
    output logic [WIDTH-1:0] mp_y,
    input  logic             mp_done,
    input  logic [WIDTH-1:0] mp_result,
    output logic             mont_start,
    output logic [WIDTH-1:0] mont_a,
    output logic [WIDTH-1:0] mont_b,
    input  logic             mont_done,
    input  logic [WIDTH-1:0] mont_result,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             finish
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        STEP = 3'd2,
        MUL  = 3'd3,
        SQR  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] n_reg, n_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [WIDTH-1:0] t_reg, t_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [CNT_W-1:0] idx_reg, idx_next, idx_inc;
    logic             mp_start_reg, mp_start_next;
    logic             mont_start_reg, mont_start_next;
    logic             finish_reg, finish_next;
    logic             d_bit, last_bit, mul_ends_run;

    // The modulus is captured for the run but never used here: the units
    // see N directly. Reducing it keeps the register observed.
    logic unused_n;
    assign unused_n = ^n_reg;

    assign idx_inc  = idx_reg + CNT_W'(1);
    assign d_bit    = |(d_reg & (WIDTH'(1) << idx_reg));
    assign last_bit = (idx_reg == CNT_W'(WIDTH - 1));

`ifdef EARLY_TERM_EN
    logic rest_zero;
    assign rest_zero = ((d_reg >> idx_reg) == '0);
    // After the multiply for the highest set bit, no further square is useful.
    assign mul_ends_run = last_bit || ((d_reg >> idx_inc) == '0);
`else
    assign mul_ends_run = last_bit;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            n_reg          <= '0;
            y_reg          <= '0;
            d_reg          <= '0;
            m_reg          <= '0;
            t_reg          <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            result_reg     <= '0;
            idx_reg        <= '0;
            mp_start_reg   <= 1'b0;
            mont_start_reg <= 1'b0;
            finish_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            n_reg          <= n_next;
            y_reg          <= y_next;
            d_reg          <= d_next;
            m_reg          <= m_next;
            t_reg          <= t_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            result_reg     <= result_next;
            idx_reg        <= idx_next;
            mp_start_reg   <= mp_start_next;
            mont_start_reg <= mont_start_next;
            finish_reg     <= finish_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        n_next          = n_reg;
        y_next          = y_reg;
        d_next          = d_reg;
        m_next          = m_reg;
        t_next          = t_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        result_next     = result_reg;
        idx_next        = idx_reg;
        mp_start_next   = 1'b0;
        mont_start_next = 1'b0;
        finish_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    n_next        = N;
                    y_next        = y;
                    d_next        = d;
                    m_next        = WIDTH'(1);
                    idx_next      = '0;
                    mp_start_next = 1'b1;
                    state_next    = PREP;
                end
            end
            PREP: begin
                if (mp_done) begin
                    t_next     = mp_result;
                    state_next = STEP;
                end
            end
            STEP: begin
`ifdef EARLY_TERM_EN
                if (rest_zero) begin
                    state_next = DONE;
                end else
`endif
                if (d_bit) begin
                    mont_start_next = 1'b1;
                    a_next          = m_reg;
                    b_next          = t_reg;
                    state_next      = MUL;
                end else if (last_bit) begin
                    state_next = DONE;
                end else begin
                    mont_start_next = 1'b1;
                    a_next          = t_reg;
                    b_next          = t_reg;
                    state_next      = SQR;
                end
            end
            MUL: begin
                if (mont_done) begin
                    m_next = mont_result;
                    if (mul_ends_run) begin
                        state_next = DONE;
                    end else begin
                        mont_start_next = 1'b1;
                        a_next          = t_reg;
                        b_next          = t_reg;
                        state_next      = SQR;
                    end
                end
            end
            SQR: begin
                if (mont_done) begin
                    t_next     = mont_result;
                    idx_next   = idx_inc;
                    state_next = STEP;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Load result and raise finish on the way into DONE, so both are
        // visible while the FSM sits in DONE.
        if (state_next == DONE && state_reg != DONE) begin
            result_next = m_next;
            finish_next = 1'b1;
        end
    end

    assign mp_start   = mp_start_reg;
    assign mp_y       = y_reg;
    assign mont_start = mont_start_reg;
    assign mont_a     = a_reg;
    assign mont_b     = b_reg;
    assign busy       = (state_reg != IDLE);
    assign result     = result_reg;
    assign finish     = finish_reg;

endmodule

// File: tb/tb_rsa_exp_scheduler.sv
// Testbench for rsa_exp_scheduler. It models the modulo-product unit
// (3-cycle latency) and the Montgomery multiplier (5-cycle latency). A
// scoreboard queue holds the expected result and the expected number of
// Montgomery requests per run. The expected values come from a plain
// square-and-multiply modular exponentiation.
module tb_rsa_exp_scheduler;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] n_in = '0;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] d_in = '0;
    logic         mp_start;
    logic [W-1:0] mp_y;
    logic         mp_done = 1'b0;
    logic [W-1:0] mp_result = '0;
    logic         mont_start;
    logic [W-1:0] mont_a;
    logic [W-1:0] mont_b;
    logic         mont_done = 1'b0;
    logic [W-1:0] mont_result = '0;
    logic         busy;
    logic [W-1:0] result;
    logic         finish;

    rsa_exp_scheduler #(.WIDTH(W), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .N(n_in), .y(y_in), .d(d_in),
        .mp_start(mp_start), .mp_y(mp_y), .mp_done(mp_done), .mp_result(mp_result),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b),
        .mont_done(mont_done), .mont_result(mont_result),
        .busy(busy), .result(result), .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           pulses;
    } exp_t;

    exp_t         exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           pulse_cnt = 0;
    logic [W-1:0] model_n = '0;
    logic [W-1:0] mp_cap = '0;
    logic [W-1:0] a_cap = '0;
    logic [W-1:0] b_cap = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: y^d mod n by plain square-and-multiply.
    function automatic logic [W-1:0] modexp(input logic [W-1:0] n, input logic [W-1:0] yv,
                                            input logic [W-1:0] dv);
        logic [2*W-1:0] r, b, nn;
        nn = {{W{1'b0}}, n};
        r  = 1;
        b  = {{W{1'b0}}, yv} % nn;
        for (int i = 0; i < W; i++) begin
            if (dv[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        r = r % nn;
        return r[W-1:0];
    endfunction

    function automatic int exp_pulses(input logic [W-1:0] dv);
        int pc, msb;
        pc  = 0;
        msb = 0;
        for (int i = 0; i < W; i++) begin
            if (dv[i]) begin
                pc++;
                msb = i;
            end
        end
`ifdef EARLY_TERM_EN
        return pc + msb;
`else
        return pc + W - 1;
`endif
    endfunction

    // Montgomery unit model: a*b*2^-W mod n, bit-serial reduction.
    function automatic logic [W-1:0] mont_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] n);
        logic [W+1:0] u;
        u = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) u = u + {2'b00, b};
            if (u[0]) u = u + {2'b00, n};
            u = u >> 1;
        end
        if (u >= {2'b00, n}) u = u - {2'b00, n};
        return u[W-1:0];
    endfunction

    function automatic logic [W-1:0] mp_model(input logic [W-1:0] yv, input logic [W-1:0] n);
        logic [2*W-1:0] p;
        p = {yv, {W{1'b0}}} % {{W{1'b0}}, n};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Modulo-product unit model (3-cycle latency).
    always begin
        @(posedge clk);
        if (mp_start === 1'b1) begin
            mp_cap = mp_y;
            repeat (2) @(posedge clk);
            #1;
            if (rst) chk("mp_y_stable", mp_y, mp_cap);
            mp_result = mp_model(mp_cap, model_n);
            mp_done   = 1'b1;
            @(posedge clk);
            #1;
            mp_done   = 1'b0;
            mp_result = '0;
        end
    end

    // Montgomery multiplier model (5-cycle latency).
    always begin
        @(posedge clk);
        if (mont_start === 1'b1) begin
            a_cap = mont_a;
            b_cap = mont_b;
            repeat (4) @(posedge clk);
            #1;
            if (rst) begin
                chk("mont_a_stable", mont_a, a_cap);
                chk("mont_b_stable", mont_b, b_cap);
            end
            mont_result = mont_model(a_cap, b_cap, model_n);
            mont_done   = 1'b1;
            @(posedge clk);
            #1;
            mont_done   = 1'b0;
            mont_result = '0;
        end
    end

    // Monitor: counts Montgomery requests and scores each finish pulse.
    always @(negedge clk) begin
        if (mont_start === 1'b1) pulse_cnt++;
        if (finish === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_finish", W'(1), W'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("mont_pulses", W'(pulse_cnt), W'(e.pulses));
                chk("busy_at_finish", W'(busy), W'(1));
            end
            pulse_cnt = 0;
        end
    end

    task automatic issue(input logic [W-1:0] n, input logic [W-1:0] yv, input logic [W-1:0] dv);
        exp_t e;
        @(posedge clk);
        #1;
        n_in    = n;
        y_in    = yv;
        d_in    = dv;
        model_n = n;
        e.res    = modexp(n, yv, dv);
        e.pulses = exp_pulses(dv);
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns at the falling edge of the cycle in which finish is high.
    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (finish !== 1'b1 && c < 8000) begin
            @(negedge clk);
            c++;
        end
        if (finish !== 1'b1) chk({name, "_timeout"}, W'(0), W'(1));
    endtask

    initial begin
        logic [W-1:0] rn, ry, rd;
        logic [W-1:0] big_n;

        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_finish", W'(finish), W'(0));
        chk("rst_mp_start", W'(mp_start), W'(0));
        chk("rst_mont_start", W'(mont_start), W'(0));
        rst = 1'b1;

        // 33, 4, 3 -> 31.
        issue(W'(33), W'(4), W'(3));
        wait_done("t1");
        $display("run N=33 y=4 d=3 result=%0d", result);
        // A start raised during the DONE cycle must be ignored.
        n_in  = W'(55);
        y_in  = W'(2);
        d_in  = W'(9);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_done", W'(busy), W'(0));
        chk("result_hold", result, W'(31));

        // d = 0, then immediately a start in the cycle after finish.
        issue(W'(33), W'(7), W'(0));
        wait_done("t2");
        $display("run N=33 y=7 d=0 result=%0d", result);
        big_n = (W'(1) << 255) + W'(95);
        issue(big_n, W'(12345), W'(65537));
        wait_done("t3");
        $display("run N=2^255+95 y=12345 d=65537 result=%0h", result);

        // A second start while busy must not disturb the run.
        issue(W'(101), W'(5), W'(7));
        repeat (20) @(negedge clk);
        n_in  = W'(55);
        y_in  = W'(9);
        d_in  = W'(200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mp_y_held", mp_y, W'(5));
        chk("busy_mid_run", W'(busy), W'(1));
        wait_done("t4");
        $display("run N=101 y=5 d=7 result=%0d", result);

        // Abort during the first square (d bit 0 clear, so the first op squares).
        issue(W'(33), W'(4), W'(2));
        begin
            int c;
            c = 0;
            while (mont_start !== 1'b1 && c < 100) begin
                @(negedge clk);
                c++;
            end
            if (mont_start !== 1'b1) chk("t5_sqr_timeout", W'(0), W'(1));
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_result", result, W'(0));
        chk("abort_mont_start", W'(mont_start), W'(0));
        chk("abort_mont_a", mont_a, W'(0));
        chk("abort_mp_y", mp_y, W'(0));
        exp_q.delete();
        pulse_cnt = 0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        pulse_cnt = 0;
        issue(W'(33), W'(4), W'(2));
        wait_done("t5");
        $display("run after abort N=33 y=4 d=2 result=%0d", result);

        // Randomized runs with odd full-width moduli.
        for (int k = 0; k < 3; k++) begin
            rn = rand256();
            rn[0]   = 1'b1;
            rn[W-1] = 1'b1;
            ry = rand256() % rn;
            rd = rand256();
            issue(rn, ry, rd);
            wait_done("rand");
            $display("random run %0d result=%0h", k, result);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", W'(exp_q.size()), W'(0));
        chk("idle_at_end", W'(busy), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
